nbadr_sched: RTL and testbench

- Write-port scheduler for the SCA next-block address memory and allocator.
- Shares the single block-memory write port between four requesters:
  - LCT allocation (link the next block),
  - no-L1A release,
  - yes-L1A mark,
  - FIFO-readout free-block.
- Drives the one-hot path selects, NBSEL, WRENA and the held per-path addresses that the allocator muxes onto its write address.
- Sits between the L1A/readout control logic and the next-block allocator.

---
 rtl/nbadr_sched_if.sv | 43 ++++
 rtl/nbadr_sched.sv | 152 +++++++++++++++
 tb/tb_nbadr_sched.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nbadr_sched_if.sv
// Bundle of request, select and status signals between the L1A/readout control,
// the write-port scheduler and the next-block allocator.
interface nbadr_sched_if #(
  parameter int CYC_W = 8
);
  logic             LCT_REQ;
  logic             NL1A_REQ;
  logic [3:0]       NL1A_IN;
  logic             YL1A_REQ;
  logic [3:0]       YL1A_IN;
  logic             FB_REQ;
  logic [3:0]       FB_IN;
  logic             SCAFULL;
  logic             PATHASEL;
  logic             PATHBSEL;
  logic             PATHCSEL;
  logic             PATHDSEL;
  logic             NBSEL;
  logic             WRENA;
  logic [3:0]       NL1A_ADR;
  logic [3:0]       YL1A_ADR;
  logic [3:0]       FB_ADR;
  logic             NL1A_BUSY;
  logic             YL1A_BUSY;
  logic             FB_BUSY;
  logic             LCT_DROP;
  logic [2:0]       OVFL;
  logic [CYC_W-1:0] GRANT_CNT;

  modport master (
    output LCT_REQ, NL1A_REQ, NL1A_IN, YL1A_REQ, YL1A_IN, FB_REQ, FB_IN, SCAFULL,
    input  PATHASEL, PATHBSEL, PATHCSEL, PATHDSEL, NBSEL, WRENA,
           NL1A_ADR, YL1A_ADR, FB_ADR, NL1A_BUSY, YL1A_BUSY, FB_BUSY,
           LCT_DROP, OVFL, GRANT_CNT
  );

  modport slave (
    input  LCT_REQ, NL1A_REQ, NL1A_IN, YL1A_REQ, YL1A_IN, FB_REQ, FB_IN, SCAFULL,
    output PATHASEL, PATHBSEL, PATHCSEL, PATHDSEL, NBSEL, WRENA,
           NL1A_ADR, YL1A_ADR, FB_ADR, NL1A_BUSY, YL1A_BUSY, FB_BUSY,
           LCT_DROP, OVFL, GRANT_CNT
  );
endinterface

// File: rtl/nbadr_sched.sv
// Shares the single next-block memory write port between LCT allocation, no-L1A
// release, yes-L1A mark and readout free-block, one 3-cycle write at a time.
module nbadr_sched #(
  parameter int CYC_W = 8
) (
  input logic         CLK,
  input logic         RST_N,
  nbadr_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, WRITE, RECOVER} state_t;
  typedef enum logic [1:0] {P_LCT, P_NL1A, P_YL1A, P_FB} path_t;

  state_t           state_q, state_d;
  path_t            grant_q, grant_d;
  logic [1:0]       rr_last_q, rr_last_d;
  logic             lct_pend_q, lct_pend_d;
  logic             lct_drop_q, lct_drop_d;
  logic [2:0]       busy_q, busy_d;
  logic [2:0][3:0]  adr_q, adr_d;
  logic [2:0]       ovfl_q, ovfl_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;

  logic [2:0]       req;
  logic [2:0][3:0]  req_in;
  logic [2:0]       clr;
  logic             clr_lct;
  logic [1:0]       cand1, cand2;
  logic             sel_active;

  // Holding-register index 0/1/2 = NL1A/YL1A/FB, matching the OVFL bit order.
  assign req    = {bus.FB_REQ, bus.YL1A_REQ, bus.NL1A_REQ};
  assign req_in = {bus.FB_IN, bus.YL1A_IN, bus.NL1A_IN};

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  assign cand1 = rr_next(rr_last_q);
  assign cand2 = rr_next(cand1);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_last_d  = rr_last_q;
    lct_pend_d = lct_pend_q;
    lct_drop_d = 1'b0;
    busy_d     = busy_q;
    adr_d      = adr_q;
    ovfl_d     = ovfl_q;
    cnt_d      = cnt_q;
    clr        = '0;
    clr_lct    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (lct_pend_q) begin
          if (bus.SCAFULL) begin
            clr_lct    = 1'b1;
            lct_drop_d = 1'b1;
          end else begin
            grant_d = P_LCT;
            state_d = SETUP;
          end
        end else if (busy_q[cand1]) begin
          grant_d   = path_t'(cand1 + 2'd1);
          rr_last_d = cand1;
          state_d   = SETUP;
        end else if (busy_q[cand2]) begin
          grant_d   = path_t'(cand2 + 2'd1);
          rr_last_d = cand2;
          state_d   = SETUP;
        end else if (busy_q[rr_last_q]) begin
          grant_d = path_t'(rr_last_q + 2'd1);
          state_d = SETUP;
        end
      end
      SETUP: state_d = WRITE;
      WRITE: begin
        state_d = RECOVER;
        cnt_d   = cnt_q + 1'b1;
        unique case (grant_q)
          P_LCT:  clr_lct = 1'b1;
          P_NL1A: clr[0]  = 1'b1;
          P_YL1A: clr[1]  = 1'b1;
          P_FB:   clr[2]  = 1'b1;
        endcase
      end
      RECOVER: state_d = IDLE;
    endcase

    // A register being released this cycle is free for a new request.
    for (int i = 0; i < 3; i++) begin
      if (clr[i]) busy_d[i] = 1'b0;
      if (req[i]) begin
        if (busy_q[i] && !clr[i]) begin
          ovfl_d[i] = 1'b1;
        end else begin
          adr_d[i]  = req_in[i];
          busy_d[i] = 1'b1;
        end
      end
    end

    if (clr_lct) lct_pend_d = 1'b0;
    if (bus.LCT_REQ) begin
      if (lct_pend_q && !clr_lct) lct_drop_d = 1'b1;
      else                        lct_pend_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      grant_q    <= P_LCT;
      rr_last_q  <= 2'd2;
      lct_pend_q <= 1'b0;
      lct_drop_q <= 1'b0;
      busy_q     <= '0;
      adr_q      <= '0;
      ovfl_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_last_q  <= rr_last_d;
      lct_pend_q <= lct_pend_d;
      lct_drop_q <= lct_drop_d;
      busy_q     <= busy_d;
      adr_q      <= adr_d;
      ovfl_q     <= ovfl_d;
      cnt_q      <= cnt_d;
    end
  end

  // Selects decode straight from state so an async reset drops them at once.
  assign sel_active    = (state_q == SETUP) || (state_q == WRITE);
  assign bus.PATHASEL  = sel_active && (grant_q == P_LCT);
  assign bus.PATHBSEL  = sel_active && (grant_q == P_NL1A);
  assign bus.PATHCSEL  = sel_active && (grant_q == P_YL1A);
  assign bus.PATHDSEL  = sel_active && (grant_q == P_FB);
  assign bus.NBSEL     = bus.PATHASEL;
  assign bus.WRENA     = (state_q == WRITE);
  assign bus.NL1A_ADR  = adr_q[0];
  assign bus.YL1A_ADR  = adr_q[1];
  assign bus.FB_ADR    = adr_q[2];
  assign bus.NL1A_BUSY = busy_q[0];
  assign bus.YL1A_BUSY = busy_q[1];
  assign bus.FB_BUSY   = busy_q[2];
  assign bus.LCT_DROP  = lct_drop_q;
  assign bus.OVFL      = ovfl_q;
  assign bus.GRANT_CNT = cnt_q;
endmodule

// File: tb/tb_nbadr_sched.sv
// Scoreboard bench for nbadr_sched: a transaction-level reference model predicts
// every write transaction and status flag; a monitor checks each WRENA cycle.
module tb_nbadr_sched;
  logic clk;
  logic rst_n;

  nbadr_sched_if #(.CYC_W(8)) bus ();

  nbadr_sched #(.CYC_W(8)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         path;
    logic [3:0] adr;
    logic [7:0] cnt;
  } txn_t;

  txn_t sbq[$];
  int   vectors;
  int   miscompares;
  int   waitCyc;

  // Reference model: path 0 = LCT, 1..3 = NL1A/YL1A/FB; register index = path-1.
  bit         mBusy[3];
  logic [3:0] mAdr[3];
  bit         mPend;
  bit [2:0]   mOvfl;
  bit         mDrop;
  int         mPhase;
  int         mCur;
  int         mLast;
  logic [7:0] mCnt;
  int         mGrants;

  function automatic void checkValue(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 3; i++) begin
      mBusy[i] = 1'b0;
      mAdr[i]  = 4'h0;
    end
    mPend   = 1'b0;
    mOvfl   = 3'b000;
    mDrop   = 1'b0;
    mPhase  = 0;
    mCur    = 0;
    mLast   = 2;
    mCnt    = 8'h00;
    mGrants = 0;
    sbq.delete();
  endfunction

  function automatic void startTxn(int path);
    txn_t t;
    t.path = path;
    t.adr  = (path == 0) ? 4'h0 : mAdr[path-1];
    t.cnt  = mCnt;
    sbq.push_back(t);
    mCur    = path;
    mPhase  = 1;
    mGrants++;
  endfunction

  // Advances the model across the next rising edge using the inputs now driven.
  function automatic void modelStep();
    bit [2:0]   req;
    logic [3:0] din[3];
    int         clr;
    bit         clrLct;
    bit         dropNext;
    bit         busyEff;
    bit         pendEff;
    bit         granted;
    int         p;
    req      = {bus.FB_REQ, bus.YL1A_REQ, bus.NL1A_REQ};
    din[0]   = bus.NL1A_IN;
    din[1]   = bus.YL1A_IN;
    din[2]   = bus.FB_IN;
    clr      = -1;
    clrLct   = 1'b0;
    dropNext = 1'b0;
    granted  = 1'b0;
    if (mPhase == 2) begin
      mCnt = mCnt + 8'd1;
      if (mCur == 0) clrLct = 1'b1;
      else           clr = mCur - 1;
    end
    if (mPhase == 0) begin
      if (mPend) begin
        if (bus.SCAFULL) begin
          clrLct   = 1'b1;
          dropNext = 1'b1;
        end else begin
          startTxn(0);
        end
      end else begin
        for (int k = 1; k <= 3; k++) begin
          p = (mLast + k) % 3;
          if (!granted && mBusy[p]) begin
            granted = 1'b1;
            startTxn(p + 1);
            mLast = p;
          end
        end
      end
    end else begin
      mPhase = (mPhase == 3) ? 0 : mPhase + 1;
    end
    for (int i = 0; i < 3; i++) begin
      busyEff = mBusy[i] && (clr != i);
      if (req[i]) begin
        if (busyEff) mOvfl[i] = 1'b1;
        else begin
          mAdr[i]  = din[i];
          mBusy[i] = 1'b1;
        end
      end else begin
        mBusy[i] = busyEff;
      end
    end
    pendEff = mPend && !clrLct;
    if (bus.LCT_REQ) begin
      if (pendEff) dropNext = 1'b1;
      else         mPend = 1'b1;
    end else begin
      mPend = pendEff;
    end
    mDrop = dropNext;
  endfunction

  function automatic logic [3:0] expSel();
    return (mPhase == 1 || mPhase == 2) ? (4'b1000 >> mCur) : 4'b0000;
  endfunction

  task automatic checkOutput();
    logic [3:0] sel;
    sel = {bus.PATHASEL, bus.PATHBSEL, bus.PATHCSEL, bus.PATHDSEL};
    checkValue("busy", {bus.FB_BUSY, bus.YL1A_BUSY, bus.NL1A_BUSY}, {mBusy[2], mBusy[1], mBusy[0]});
    checkValue("held_adr", {bus.FB_ADR, bus.YL1A_ADR, bus.NL1A_ADR}, {mAdr[2], mAdr[1], mAdr[0]});
    checkValue("ovfl", bus.OVFL, mOvfl);
    checkValue("lct_drop", bus.LCT_DROP, mDrop);
    checkValue("grant_cnt", bus.GRANT_CNT, mCnt);
    checkValue("path_sel", sel, expSel());
    checkValue("wrena", bus.WRENA, (mPhase == 2));
    checkValue("nbsel", bus.NBSEL, (mPhase == 1 || mPhase == 2) && mCur == 0);
  endtask

  task automatic driveInputs(input bit lct, input bit nReq, input logic [3:0] nIn,
                             input bit yReq, input logic [3:0] yIn,
                             input bit fReq, input logic [3:0] fIn, input bit sf);
    bus.LCT_REQ  = lct;
    bus.NL1A_REQ = nReq;
    bus.NL1A_IN  = nIn;
    bus.YL1A_REQ = yReq;
    bus.YL1A_IN  = yIn;
    bus.FB_REQ   = fReq;
    bus.FB_IN    = fIn;
    bus.SCAFULL  = sf;
  endtask

  task automatic applyStimulus(input bit lct, input bit nReq, input logic [3:0] nIn,
                               input bit yReq, input logic [3:0] yIn,
                               input bit fReq, input logic [3:0] fIn, input bit sf);
    @(negedge clk);
    checkOutput();
    driveInputs(lct, nReq, nIn, yReq, yIn, fReq, fIn, sf);
    modelStep();
  endtask

  task automatic idleCycles(input int n, input bit sf);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 4'h0, 0, 4'h0, 0, 4'h0, sf);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    driveInputs(0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0);
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput();
    checkValue("reset_grant_cnt", bus.GRANT_CNT, 8'h00);
    rst_n = 1'b1;
    modelStep();
  endtask

  // Monitor: every write cycle must match the oldest predicted transaction.
  always @(negedge clk) begin
    txn_t       t;
    logic [3:0] sel;
    logic [3:0] adr;
    sel = {bus.PATHASEL, bus.PATHBSEL, bus.PATHCSEL, bus.PATHDSEL};
    if (rst_n) begin
      checkValue("sel_onehot", ($countones(sel) <= 1), 1);
      if (bus.WRENA) begin
        if (sbq.size() == 0) begin
          checkValue("unexpected_wrena", bus.WRENA, 0);
        end else begin
          t = sbq.pop_front();
          case (t.path)
            1:       adr = bus.NL1A_ADR;
            2:       adr = bus.YL1A_ADR;
            3:       adr = bus.FB_ADR;
            default: adr = 4'h0;
          endcase
          checkValue("txn", {sel, bus.NBSEL, adr, bus.GRANT_CNT},
                     {4'b1000 >> t.path, (t.path == 0), t.adr, t.cnt});
        end
        waitCyc = 0;
      end else if (sbq.size() != 0) begin
        waitCyc++;
        if (waitCyc > 6) begin
          checkValue("txn_timeout", 0, 1);
          void'(sbq.pop_front());
          waitCyc = 0;
        end
      end else begin
        waitCyc = 0;
      end
    end else begin
      waitCyc = 0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;

    doReset();

    // Single FB request.
    applyStimulus(0, 0, 4'h0, 0, 4'h0, 1, 4'hA, 0);
    idleCycles(6, 0);
    checkValue("fb_single_cnt", bus.GRANT_CNT, 8'd1);
    checkValue("fb_single_busy", bus.FB_BUSY, 0);

    // Three-way round robin from reset, then NL1A+FB together.
    doReset();
    applyStimulus(0, 1, 4'h1, 1, 4'h2, 1, 4'h3, 0);
    idleCycles(14, 0);
    applyStimulus(0, 1, 4'h4, 0, 4'h0, 1, 4'h5, 0);
    idleCycles(10, 0);

    // LCT priority, then LCT dropped by SCAFULL while YL1A is still served.
    applyStimulus(1, 0, 4'h0, 1, 4'h6, 0, 4'h0, 0);
    idleCycles(10, 0);
    applyStimulus(1, 0, 4'h0, 1, 4'h7, 0, 4'h0, 1);
    idleCycles(10, 1);

    // NL1A overflow: second request while the first is still held.
    doReset();
    applyStimulus(0, 1, 4'h3, 0, 4'h0, 0, 4'h0, 0);
    applyStimulus(0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0);
    applyStimulus(0, 1, 4'h5, 0, 4'h0, 0, 4'h0, 0);
    idleCycles(8, 0);
    checkValue("ovfl_adr", bus.NL1A_ADR, 4'h3);
    checkValue("ovfl_flag", bus.OVFL, 3'b001);
    applyStimulus(0, 0, 4'h0, 1, 4'h9, 0, 4'h0, 0);
    idleCycles(8, 0);
    checkValue("ovfl_sticky", bus.OVFL, 3'b001);

    // Reset asserted during WRITE.
    doReset();
    applyStimulus(0, 0, 4'h0, 0, 4'h0, 1, 4'hC, 0);
    for (int i = 0; i < 8 && mPhase != 2; i++) idleCycles(1, 0);
    @(posedge clk);
    #1;
    checkValue("wrena_before_reset", bus.WRENA, 1);
    rst_n = 1'b0;
    #1;
    checkValue("wrena_async_reset", bus.WRENA, 0);
    checkValue("sel_async_reset", {bus.PATHASEL, bus.PATHBSEL, bus.PATHCSEL, bus.PATHDSEL}, 4'b0000);
    doReset();

    // 256 back-to-back FB writes wrap the counter.
    for (int i = 0; i < 1200 && mGrants < 256; i++)
      applyStimulus(0, 0, 4'h0, 0, 4'h0, 1, 4'($urandom), 0);
    idleCycles(8, 0);
    checkValue("wrap_cnt", bus.GRANT_CNT, 8'h00);

    // Randomised traffic.
    doReset();
    for (int c = 0; c < 1500; c++)
      applyStimulus($urandom_range(5) == 0,
                    $urandom_range(3) == 0, 4'($urandom),
                    $urandom_range(3) == 0, 4'($urandom),
                    $urandom_range(3) == 0, 4'($urandom),
                    $urandom_range(7) == 0);
    idleCycles(20, 0);
    checkValue("scoreboard_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
